ex_mem_reg: RTL

- Dual-issue EX/MEM pipeline register, directly downstream of the EX stage. Captures both EX slots (ALU result, branch outcome, load/store control, destination register) and presents them to the MEM stage and D-cache.
- Owns pipeline hold, bubble and flush, plus slot-1 squash when slot 0 branches.
- Generates the single registered fetch-redirect pulse and the aligned store data, byte mask and misalignment flags.

---
 rtl/ex_mem_reg_pkg.sv | 31 +++
 rtl/ex_mem_reg_st_align.sv | 67 ++++++
 rtl/ex_mem_reg.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_pkg
// Shared definitions for the dual-issue EX/MEM pipeline register:
//   - default widths for data, address and register-file index
//   - number of issue slots
//   - load-type and store-type encodings carried down the pipe
// ---------------------------------------------------------------------------
package ex_mem_reg_pkg;

   localparam int EMR_DATA_WIDTH    = 32;
   localparam int EMR_ADDR_WIDTH    = 32;
   localparam int EMR_RF_ADDR_WIDTH = 5;
   localparam int NUM_SLOTS         = 2;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LH   = 3'd2,
      LD_LW   = 3'd3,
      LD_LBU  = 3'd4,
      LD_LHU  = 3'd5
   } ld_type_e;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_SB   = 2'd1,
      ST_SH   = 2'd2,
      ST_SW   = 2'd3
   } st_type_e;

endpackage

// File: rtl/ex_mem_reg_st_align.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_st_align
// Combinational store lane alignment and access misalignment detection for
// one issue slot.
//   st_type_i   store type (none/SB/SH/SW)
//   ld_type_i   load type (none/LB/LH/LW/LBU/LHU)
//   off_i       low two address bits (byte offset within the word)
//   rs2_i       raw store data
//   data_o      store data replicated onto every byte/half lane
//   mask_o      byte enables; zero for no store or a misaligned store
//   misalign_o  halfword/word access not naturally aligned (ungated)
// ---------------------------------------------------------------------------
module ex_mem_reg_st_align
   import ex_mem_reg_pkg::*;
#(
   parameter int DATA_WIDTH = EMR_DATA_WIDTH
)
(
   input  logic [1:0]            st_type_i,
   input  logic [2:0]            ld_type_i,
   input  logic [1:0]            off_i,
   input  logic [DATA_WIDTH-1:0] rs2_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [3:0]            mask_o,
   output logic                  misalign_o
);

   logic half_acc;
   logic word_acc;
   logic st_misalign;

   always_comb begin
      half_acc    = (st_type_i == ST_SH) || (ld_type_i == LD_LH) || (ld_type_i == LD_LHU);
      word_acc    = (st_type_i == ST_SW) || (ld_type_i == LD_LW);
      misalign_o  = (half_acc && off_i[0]) || (word_acc && (off_i != 2'd0));
      st_misalign = ((st_type_i == ST_SH) && off_i[0]) ||
                    ((st_type_i == ST_SW) && (off_i != 2'd0));

      data_o = rs2_i;
      mask_o = 4'b0000;
      case (st_type_i)
         ST_SB: begin
            // Byte copied to all lanes so the mask alone selects the lane.
            data_o = {(DATA_WIDTH/8){rs2_i[7:0]}};
            mask_o = 4'b0001 << off_i;
         end
         ST_SH: begin
            data_o = {(DATA_WIDTH/16){rs2_i[15:0]}};
            mask_o = 4'b0011 << off_i;
         end
         ST_SW: begin
            data_o = rs2_i;
            mask_o = 4'b1111;
         end
         default: begin
            data_o = rs2_i;
            mask_o = 4'b0000;
         end
      endcase

      // A misaligned store must not write anything; the trap path takes over.
      if (st_misalign) begin
         mask_o = 4'b0000;
      end
   end

endmodule

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// Dual-issue EX/MEM pipeline register. Captures both EX slots, applies
// hold (Mem_StallReq), flush (Flush) and bubble (EX_StallReq), squashes
// slot 1 behind a taken slot-0 branch, and produces a one-cycle registered
// fetch redirect plus aligned store data / byte mask / misalign flags.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   EX_* / IDEX_* _0/_1           per-slot inputs from EX and ID/EX
//   EX_StallReq, Mem_StallReq     bubble request, hold request
//   Flush                         trap/CSR flush
//   ExMem_* _0/_1                 registered per-slot outputs to MEM
//   ExMem_Redirect(PC)            single-cycle redirect pulse and target
// ---------------------------------------------------------------------------
module ex_mem_reg
   import ex_mem_reg_pkg::*;
#(
   parameter int DATA_WIDTH    = EMR_DATA_WIDTH,
   parameter int ADDR_WIDTH    = EMR_ADDR_WIDTH,
   parameter int RF_ADDR_WIDTH = EMR_RF_ADDR_WIDTH
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    EX_AluData_0,
   input  logic [DATA_WIDTH-1:0]    EX_AluData_1,
   input  logic                     EX_BranchFlag_0,
   input  logic                     EX_BranchFlag_1,
   input  logic [ADDR_WIDTH-1:0]    EX_BranchPC_0,
   input  logic [ADDR_WIDTH-1:0]    EX_BranchPC_1,
   input  logic                     EX_LdStFlag_0,
   input  logic                     EX_LdStFlag_1,
   input  logic [DATA_WIDTH-1:0]    IDEX_Rs2Data_0,
   input  logic [DATA_WIDTH-1:0]    IDEX_Rs2Data_1,
   input  logic [2:0]               IDEX_LdType_0,
   input  logic [2:0]               IDEX_LdType_1,
   input  logic [1:0]               IDEX_StType_0,
   input  logic [1:0]               IDEX_StType_1,
   input  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr_0,
   input  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr_1,
   input  logic                     IDEX_WbRdEn_0,
   input  logic                     IDEX_WbRdEn_1,
   input  logic                     IDEX_Valid_0,
   input  logic                     IDEX_Valid_1,
   input  logic                     EX_StallReq,
   input  logic                     Mem_StallReq,
   input  logic                     Flush,
   output logic                     ExMem_Valid_0,
   output logic                     ExMem_Valid_1,
   output logic [DATA_WIDTH-1:0]    ExMem_AluData_0,
   output logic [DATA_WIDTH-1:0]    ExMem_AluData_1,
   output logic [RF_ADDR_WIDTH-1:0] ExMem_RdAddr_0,
   output logic [RF_ADDR_WIDTH-1:0] ExMem_RdAddr_1,
   output logic                     ExMem_WbRdEn_0,
   output logic                     ExMem_WbRdEn_1,
   output logic [2:0]               ExMem_LdType_0,
   output logic [2:0]               ExMem_LdType_1,
   output logic [DATA_WIDTH-1:0]    ExMem_StData_0,
   output logic [DATA_WIDTH-1:0]    ExMem_StData_1,
   output logic [3:0]               ExMem_ByteMask_0,
   output logic [3:0]               ExMem_ByteMask_1,
   output logic                     ExMem_Misalign_0,
   output logic                     ExMem_Misalign_1,
   output logic                     ExMem_Redirect,
   output logic [ADDR_WIDTH-1:0]    ExMem_RedirectPC
);

   // Per-slot views of the flat input ports so both slots share one generate body.
   logic [DATA_WIDTH-1:0]    alu_in   [NUM_SLOTS];
   logic                     ldst_in  [NUM_SLOTS];
   logic [DATA_WIDTH-1:0]    rs2_in   [NUM_SLOTS];
   logic [2:0]               ld_in    [NUM_SLOTS];
   logic [1:0]               st_in    [NUM_SLOTS];
   logic [RF_ADDR_WIDTH-1:0] rd_in    [NUM_SLOTS];
   logic                     wb_in    [NUM_SLOTS];
   logic                     slot_vld [NUM_SLOTS];

   assign alu_in[0]  = EX_AluData_0;
   assign alu_in[1]  = EX_AluData_1;
   assign ldst_in[0] = EX_LdStFlag_0;
   assign ldst_in[1] = EX_LdStFlag_1;
   assign rs2_in[0]  = IDEX_Rs2Data_0;
   assign rs2_in[1]  = IDEX_Rs2Data_1;
   assign ld_in[0]   = IDEX_LdType_0;
   assign ld_in[1]   = IDEX_LdType_1;
   assign st_in[0]   = IDEX_StType_0;
   assign st_in[1]   = IDEX_StType_1;
   assign rd_in[0]   = IDEX_RdAddr_0;
   assign rd_in[1]   = IDEX_RdAddr_1;
   assign wb_in[0]   = IDEX_WbRdEn_0;
   assign wb_in[1]   = IDEX_WbRdEn_1;

   // Slot 1 is younger: a taken slot-0 branch kills it.
   assign slot_vld[0] = IDEX_Valid_0;
   assign slot_vld[1] = IDEX_Valid_1 & ~(IDEX_Valid_0 & EX_BranchFlag_0);

   // Bubble and flush have identical effect on the register contents.
   logic kill;
   assign kill = Flush | EX_StallReq;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         logic [DATA_WIDTH-1:0]    st_data_c;
         logic [3:0]               mask_c;
         logic                     mis_c;

         logic                     valid_q;
         logic [DATA_WIDTH-1:0]    alu_q;
         logic [RF_ADDR_WIDTH-1:0] rd_q;
         logic                     wb_q;
         logic [2:0]               ld_q;
         logic [DATA_WIDTH-1:0]    st_data_q;
         logic [3:0]               mask_q;
         logic                     mis_q;

         ex_mem_reg_st_align #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_st_align (
            .st_type_i  (st_in[gi]),
            .ld_type_i  (ld_in[gi]),
            .off_i      (alu_in[gi][1:0]),
            .rs2_i      (rs2_in[gi]),
            .data_o     (st_data_c),
            .mask_o     (mask_c),
            .misalign_o (mis_c)
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q   <= 1'b0;
               alu_q     <= '0;
               rd_q      <= '0;
               wb_q      <= 1'b0;
               ld_q      <= '0;
               st_data_q <= '0;
               mask_q    <= '0;
               mis_q     <= 1'b0;
            end else if (!Mem_StallReq) begin
               if (kill) begin
                  // Payload fields are left as-is; valid=0 makes them don't-care.
                  valid_q <= 1'b0;
                  wb_q    <= 1'b0;
                  mask_q  <= '0;
                  mis_q   <= 1'b0;
               end else begin
                  valid_q   <= slot_vld[gi];
                  alu_q     <= alu_in[gi];
                  rd_q      <= rd_in[gi];
                  wb_q      <= wb_in[gi] & slot_vld[gi];
                  ld_q      <= ld_in[gi];
                  st_data_q <= st_data_c;
                  mask_q    <= slot_vld[gi] ? mask_c : 4'b0000;
                  mis_q     <= slot_vld[gi] & ldst_in[gi] & mis_c;
               end
            end
         end
      end
   endgenerate

   // Redirect: oldest taken branch among the captured valid slots.
   logic                  redirect_d;
   logic [ADDR_WIDTH-1:0] redirect_pc_d;
   logic                  redirect_q;
   logic [ADDR_WIDTH-1:0] redirect_pc_q;

   always_comb begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (slot_vld[0] && EX_BranchFlag_0) begin
         redirect_d    = 1'b1;
         redirect_pc_d = EX_BranchPC_0;
      end else if (slot_vld[1] && EX_BranchFlag_1) begin
         redirect_d    = 1'b1;
         redirect_pc_d = EX_BranchPC_1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else if (Mem_StallReq || kill) begin
         // Pulse never repeats while held; target stays for observability.
         redirect_q <= 1'b0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign ExMem_Valid_0    = g_slot[0].valid_q;
   assign ExMem_Valid_1    = g_slot[1].valid_q;
   assign ExMem_AluData_0  = g_slot[0].alu_q;
   assign ExMem_AluData_1  = g_slot[1].alu_q;
   assign ExMem_RdAddr_0   = g_slot[0].rd_q;
   assign ExMem_RdAddr_1   = g_slot[1].rd_q;
   assign ExMem_WbRdEn_0   = g_slot[0].wb_q;
   assign ExMem_WbRdEn_1   = g_slot[1].wb_q;
   assign ExMem_LdType_0   = g_slot[0].ld_q;
   assign ExMem_LdType_1   = g_slot[1].ld_q;
   assign ExMem_StData_0   = g_slot[0].st_data_q;
   assign ExMem_StData_1   = g_slot[1].st_data_q;
   assign ExMem_ByteMask_0 = g_slot[0].mask_q;
   assign ExMem_ByteMask_1 = g_slot[1].mask_q;
   assign ExMem_Misalign_0 = g_slot[0].mis_q;
   assign ExMem_Misalign_1 = g_slot[1].mis_q;
   assign ExMem_Redirect   = redirect_q;
   assign ExMem_RedirectPC = redirect_pc_q;

endmodule
